// File: rtl/fft_bfly_pe.sv
// -----------------------------------------------------------------------------
// fft_bfly_pe -- pipelined radix-2 DIT butterfly processing element.
//
// Computes fft_a = a + b*W and fft_b = a - b*W on packed complex operands
// ({re, im}, two's complement) through three register stages:
//   stage 1 : register a and the four full-precision partial products of b*W
//   stage 2 : combine products, round to nearest (half up), form a +/- p
//   stage 3 : optional 1/2 scaling, saturation, output registers
// A single enable (en = !out_valid || out_ready) advances all stages, so a
// stalled output freezes the whole pipeline without dropping or duplicating
// data. Latency is 3 cycles, throughput one butterfly per cycle.
//
// Configuration macro:
//   FFT_BFLY_PE_SCALE_EN  defined   -> stage 3 applies (x + 1) >>> 1 to every
//                                      sum/diff component before saturation
//                         undefined -> saturation only
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   a, b, tw        operands and twiddle, 2*DW bits each, {re, im}
//                   (tw is Q(DW-1-FRAC).FRAC, 1.0 = 2^FRAC)
//   in_valid        a/b/tw valid this cycle
//   in_ready        block accepts a/b/tw this cycle (combinational)
//   fft_a, fft_b    butterfly results, 2*DW bits each, {re, im}
//   out_valid       fft_a/fft_b valid
//   out_ready       downstream accepts the output
//   frame_done      high with out_valid on the last butterfly of a frame
//   ovf             sticky saturation flag
//   clr_ovf         synchronous clear of ovf (a same-cycle set wins)
// -----------------------------------------------------------------------------
module fft_bfly_pe #(
   parameter int DW    = 16,
   parameter int FRAC  = 14,
   parameter int NPAIR = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [2*DW-1:0] a,
   input  logic [2*DW-1:0] b,
   input  logic [2*DW-1:0] tw,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [2*DW-1:0] fft_a,
   output logic [2*DW-1:0] fft_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            frame_done,
   output logic            ovf,
   input  logic            clr_ovf
);

   localparam int PW  = 2 * DW;   // product width
   localparam int XW  = PW + 1;   // width of a sum/difference of two products
   localparam int SW  = DW + 2;   // stage-2 sum/diff width
   localparam int TW3 = DW + 3;   // stage-3 width, headroom for the +1 of scaling
   localparam int CW  = (NPAIR > 1) ? $clog2(NPAIR) : 1;

   localparam logic [CW-1:0]         LAST = CW'(NPAIR - 1);
   localparam logic signed [XW-1:0]  RND  = XW'(1) <<< (FRAC - 1);
   localparam logic signed [TW3-1:0] MAXV = TW3'((64'sd1 <<< (DW - 1)) - 64'sd1);
   localparam logic signed [TW3-1:0] MINV = TW3'(-(64'sd1 <<< (DW - 1)));

   // ---------------------------------------------------------------------------
   // Flow control: one enable for every stage.
   // ---------------------------------------------------------------------------
   logic en;
   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   // ---------------------------------------------------------------------------
   // Stage 1: operand split and full-precision partial products.
   // ---------------------------------------------------------------------------
   logic signed [PW-1:0] b_re_x, b_im_x, w_re_x, w_im_x;
   assign b_re_x = PW'($signed(b[PW-1:DW]));
   assign b_im_x = PW'($signed(b[DW-1:0]));
   assign w_re_x = PW'($signed(tw[PW-1:DW]));
   assign w_im_x = PW'($signed(tw[DW-1:0]));

   logic                 v1;
   logic signed [DW-1:0] a_re1, a_im1;
   logic signed [PW-1:0] m_rr, m_ii, m_ri, m_ir;

   // NOTE: clocked state is assigned with <= so every register samples the
   // pre-edge value of its source; blocking = here would let a later stage see
   // this cycle's new value and collapse the pipeline.
   // NOTE: datapath registers are reset too, so fft_a/fft_b read zero after
   // reset and nothing downstream ever observes X from an unloaded stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1    <= 1'b0;
         a_re1 <= '0;
         a_im1 <= '0;
         m_rr  <= '0;
         m_ii  <= '0;
         m_ri  <= '0;
         m_ir  <= '0;
      end else if (en) begin
         v1    <= in_valid;
         a_re1 <= $signed(a[PW-1:DW]);
         a_im1 <= $signed(a[DW-1:0]);
         m_rr  <= b_re_x * w_re_x;
         m_ii  <= b_im_x * w_im_x;
         m_ri  <= b_re_x * w_im_x;
         m_ir  <= b_im_x * w_re_x;
      end
   end

   // ---------------------------------------------------------------------------
   // Stage 2: complex product, round half up, add/subtract.
   // ---------------------------------------------------------------------------
   logic signed [XW-1:0] p_re_full, p_im_full;
   logic signed [SW-1:0] p_re, p_im, a_re_x, a_im_x;

   assign p_re_full = XW'(m_rr) - XW'(m_ii);
   assign p_im_full = XW'(m_ri) + XW'(m_ir);
   // Adding half an LSB before the arithmetic shift rounds to nearest, ties up.
   assign p_re      = SW'((p_re_full + RND) >>> FRAC);
   assign p_im      = SW'((p_im_full + RND) >>> FRAC);
   assign a_re_x    = SW'(a_re1);
   assign a_im_x    = SW'(a_im1);

   logic                 v2;
   logic signed [SW-1:0] sum_re2, sum_im2, dif_re2, dif_im2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2      <= 1'b0;
         sum_re2 <= '0;
         sum_im2 <= '0;
         dif_re2 <= '0;
         dif_im2 <= '0;
      end else if (en) begin
         v2      <= v1;
         sum_re2 <= a_re_x + p_re;
         sum_im2 <= a_im_x + p_im;
         dif_re2 <= a_re_x - p_re;
         dif_im2 <= a_im_x - p_im;
      end
   end

   // ---------------------------------------------------------------------------
   // Stage 3: optional scaling, saturation, output registers.
   // ---------------------------------------------------------------------------
   function automatic logic signed [TW3-1:0] scale(input logic signed [SW-1:0] x);
`ifdef FFT_BFLY_PE_SCALE_EN
      return (TW3'(x) + TW3'(1)) >>> 1;
`else
      return TW3'(x);
`endif
   endfunction

   function automatic logic [DW-1:0] sat(input logic signed [TW3-1:0] x);
      if (x > MAXV)      return DW'(MAXV);
      else if (x < MINV) return DW'(MINV);
      else               return x[DW-1:0];
   endfunction

   function automatic logic is_sat(input logic signed [TW3-1:0] x);
      return (x > MAXV) || (x < MINV);
   endfunction

   logic signed [TW3-1:0] s_ar, s_ai, s_br, s_bi;
   logic                  any_sat;

   assign s_ar    = scale(sum_re2);
   assign s_ai    = scale(sum_im2);
   assign s_br    = scale(dif_re2);
   assign s_bi    = scale(dif_im2);
   assign any_sat = is_sat(s_ar) || is_sat(s_ai) || is_sat(s_br) || is_sat(s_bi);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         fft_a     <= '0;
         fft_b     <= '0;
      end else if (en) begin
         out_valid <= v2;
         // Bubbles leave the last result in place rather than zeroing it.
         if (v2) begin
            fft_a <= {sat(s_ar), sat(s_ai)};
            fft_b <= {sat(s_br), sat(s_bi)};
         end
      end
   end

   // Sticky overflow: a saturating load in the same cycle beats clr_ovf.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                       ovf <= 1'b0;
      else if (en && v2 && any_sat)  ovf <= 1'b1;
      else if (clr_ovf)              ovf <= 1'b0;
   end

   // ---------------------------------------------------------------------------
   // Frame counter: counts output transfers, wraps after the last butterfly.
   // ---------------------------------------------------------------------------
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (out_valid && out_ready) begin
         cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
      end
   end

   assign frame_done = out_valid && (cnt == LAST);

endmodule

// File: tb/tb_fft_bfly_pe.sv
// -----------------------------------------------------------------------------
// tb_fft_bfly_pe -- self-checking bench for fft_bfly_pe (DW=16, FRAC=14,
// NPAIR=8). Hand-computed vectors live in a table; random vectors use a
// longint reference model. Expected results are queued when an input transfer
// is seen and compared in order when an output transfer is seen.
// -----------------------------------------------------------------------------
module tb_fft_bfly_pe;

   localparam int DW    = 16;
   localparam int FRAC  = 14;
   localparam int NPAIR = 8;

`ifdef FFT_BFLY_PE_SCALE_EN
   localparam bit SCALE = 1'b1;
`else
   localparam bit SCALE = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] a = '0, b = '0, tw = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] fft_a, fft_b;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        frame_done;
   logic        ovf;
   logic        clr_ovf = 1'b0;

   fft_bfly_pe #(.DW(DW), .FRAC(FRAC), .NPAIR(NPAIR)) dut (
      .clk        (clk),
      .rst        (rst),
      .a          (a),
      .b          (b),
      .tw         (tw),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .fft_a      (fft_a),
      .fft_b      (fft_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .frame_done (frame_done),
      .ovf        (ovf),
      .clr_ovf    (clr_ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a, b, tw;
      logic [31:0] ea, eb;   // expected, no scaling
      logic [31:0] sa, sb;   // expected, with 1/2 scaling
   } vec_t;

   typedef struct {
      logic [31:0] ea, eb;
   } exp_t;

   vec_t        tbl [8];
   exp_t        sb_q [$];
   logic [31:0] drv_ea = '0, drv_eb = '0;
   int          n_checks = 0;
   int          n_fail   = 0;
   int          out_cnt  = 0;
   int          fd_seen  = 0;
   int          frame_pos = 0;

   // ---------------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out (t=%0t)", name, $time);
   endtask

   function automatic logic [31:0] pk(input int re, input int im);
      return {16'(re), 16'(im)};
   endfunction

   function automatic vec_t mk(input logic [31:0] va, vb, vt, ea, eb, sa, sb);
      vec_t t;
      t.a = va; t.b = vb; t.tw = vt; t.ea = ea; t.eb = eb; t.sa = sa; t.sb = sb;
      return t;
   endfunction

   function automatic logic [15:0] clamp16(input longint x);
      if (x > 32767)  return 16'h7fff;
      if (x < -32768) return 16'h8000;
      return 16'(x);
   endfunction

   function automatic longint scl(input longint x);
      return SCALE ? ((x + 1) >>> 1) : x;
   endfunction

   // Reference butterfly in wide integer arithmetic.
   function automatic void model(input logic [31:0] va, vb, vt,
                                 output logic [31:0] ea, output logic [31:0] eb);
      longint ar, ai, br, bi, wr, wi, pr, pi;
      ar = longint'($signed(va[31:16]));
      ai = longint'($signed(va[15:0]));
      br = longint'($signed(vb[31:16]));
      bi = longint'($signed(vb[15:0]));
      wr = longint'($signed(vt[31:16]));
      wi = longint'($signed(vt[15:0]));
      pr = ((br * wr - bi * wi) + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
      pi = ((br * wi + bi * wr) + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
      ea = {clamp16(scl(ar + pr)), clamp16(scl(ai + pi))};
      eb = {clamp16(scl(ar - pr)), clamp16(scl(ai - pi))};
   endfunction

   // Called at posedge+1; holds the inputs until accepted, returns at posedge+1.
   task automatic send(input logic [31:0] va, vb, vt, ea, eb);
      bit ok = 1'b0;
      a = va; b = vb; tw = vt; drv_ea = ea; drv_eb = eb;
      in_valid = 1'b1;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
      end
      if (!ok) timeout_fail("send");
      @(posedge clk);
      #1;
   endtask

   task automatic send_vec(input vec_t t);
      send(t.a, t.b, t.tw, SCALE ? t.sa : t.ea, SCALE ? t.sb : t.eb);
   endtask

   task automatic send_rand();
      logic [31:0] va, vb, vt, ea, eb;
      va = $urandom;
      vb = $urandom;
      vt = {16'($urandom_range(0, 32768)) - 16'd16384,
            16'($urandom_range(0, 32768)) - 16'd16384};
      model(va, vb, vt, ea, eb);
      send(va, vb, vt, ea, eb);
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   // Wait (at negedges) until out_valid is seen.
   task automatic wait_valid(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (out_valid) ok = 1'b1;
      end
      if (!ok) timeout_fail(name);
   endtask

   // Poll at posedges until out_cnt reaches target; returns at posedge+1.
   task automatic wait_outs(input int target, input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(posedge clk);
         if (out_cnt >= target) ok = 1'b1;
      end
      if (!ok) timeout_fail(name);
      #1;
   endtask

   // Wait for the pipeline and the scoreboard to empty; returns at posedge+1.
   task automatic drain(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 500 && !ok; i++) begin
         @(posedge clk);
         #1;
         if (sb_q.size() == 0 && !out_valid) ok = 1'b1;
      end
      if (!ok) timeout_fail(name);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   // Scoreboard: push on input transfer, pop and compare on output transfer.
   // ---------------------------------------------------------------------------
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         sb_q.delete();
         frame_pos = 0;
      end else begin
         if (in_valid && in_ready) begin
            e.ea = drv_ea;
            e.eb = drv_eb;
            sb_q.push_back(e);
         end
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_output: got %0h with no pending input", fft_a);
            end else begin
               e = sb_q.pop_front();
               check("fft_a", 64'(fft_a), 64'(e.ea));
               check("fft_b", 64'(fft_b), 64'(e.eb));
            end
            check("frame_done", 64'(frame_done), 64'(frame_pos == NPAIR - 1));
            if (frame_done) fd_seen++;
            frame_pos = (frame_pos == NPAIR - 1) ? 0 : frame_pos + 1;
            out_cnt++;
         end else if (!out_valid) begin
            check("frame_done_idle", 64'(frame_done), 64'(0));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------------------
   initial begin
      int          base;
      int          fd0;
      bit          done;
      logic [31:0] held_a, held_b;

      tbl[0] = mk(pk(100, 0),     pk(50, 0),     pk(16384, 0),
                  pk(150, 0),     pk(50, 0),     pk(75, 0),     pk(25, 0));
      tbl[1] = mk(pk(0, 0),       pk(0, 100),    pk(0, -16384),
                  pk(100, 0),     pk(-100, 0),   pk(50, 0),     pk(-50, 0));
      tbl[2] = mk(pk(32767, 0),   pk(32767, 0),  pk(16384, 0),
                  pk(32767, 0),   pk(0, 0),      pk(32767, 0),  pk(0, 0));
      tbl[3] = mk(pk(0, 0),       pk(1, 0),      pk(8192, 0),
                  pk(1, 0),       pk(-1, 0),     pk(1, 0),      pk(0, 0));
      tbl[4] = mk(pk(10, -20),    pk(-1, 0),     pk(8192, 0),
                  pk(10, -20),    pk(10, -20),   pk(5, -10),    pk(5, -10));
      tbl[5] = mk(pk(-32768, 0),  pk(32767, 0),  pk(-16384, 0),
                  pk(-32768, 0),  pk(-1, 0),     pk(-32767, 0), pk(0, 0));
      tbl[6] = mk(pk(1000, -2000), pk(300, 400), pk(11585, -11585),
                  pk(1495, -1929), pk(505, -2071), pk(748, -964), pk(253, -1035));
      tbl[7] = mk(pk(0, 30000),   pk(0, 10000),  pk(16384, 0),
                  pk(0, 32767),   pk(0, 20000),  pk(0, 20000),  pk(0, 10000));

      // Reset state
      #2 rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_out_valid",  64'(out_valid),  64'(0));
      check("rst_frame_done", 64'(frame_done), 64'(0));
      check("rst_ovf",        64'(ovf),        64'(0));
      check("rst_fft_a",      64'(fft_a),      64'(0));
      check("rst_fft_b",      64'(fft_b),      64'(0));
      check("rst_in_ready",   64'(in_ready),   64'(1));
      @(posedge clk);
      #1 rst = 1'b0;

      // Latency of exactly three cycles, then a bubble with held outputs
      send_vec(tbl[0]);
      idle();
      @(negedge clk) check("lat_cycle1", 64'(out_valid), 64'(0));
      @(negedge clk) check("lat_cycle2", 64'(out_valid), 64'(0));
      @(negedge clk) check("lat_cycle3", 64'(out_valid), 64'(1));
      @(negedge clk) check("bubble_out_valid", 64'(out_valid), 64'(0));
      check("bubble_hold_a", 64'(fft_a), 64'(SCALE ? tbl[0].sa : tbl[0].ea));
      check("bubble_hold_b", 64'(fft_b), 64'(SCALE ? tbl[0].sb : tbl[0].eb));
      @(posedge clk);
      #1;

      // Sticky overflow and its clear
      send_vec(tbl[2]);
      idle();
      wait_valid("ovf_wait");
      check("ovf_set", 64'(ovf), 64'(!SCALE));
      @(posedge clk);
      #1 clr_ovf = 1'b1;
      @(posedge clk);
      #1 clr_ovf = 1'b0;
      @(negedge clk) check("ovf_clr", 64'(ovf), 64'(0));

      // Set beats a simultaneous clear
      @(posedge clk);
      #1 clr_ovf = 1'b1;
      send_vec(tbl[2]);
      idle();
      wait_valid("ovf2_wait");
      check("ovf_set_over_clr", 64'(ovf), 64'(!SCALE));
      @(posedge clk);
      #1 clr_ovf = 1'b0;
      @(negedge clk) check("ovf_clr_after", 64'(ovf), 64'(0));
      @(posedge clk);
      #1;

      // Table vectors back to back
      for (int i = 0; i < 8; i++) send_vec(tbl[i]);
      idle();
      drain("drain_table");

      // Random vectors with random gaps and random backpressure
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 24; i++) begin
               send_rand();
               if ($urandom_range(0, 3) == 0) begin
                  idle();
                  repeat ($urandom_range(1, 2)) begin
                     @(posedge clk);
                     #1;
                  end
               end
            end
            idle();
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1 out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      drain("drain_random");

      // Full frame with a 4-cycle stall after the 2nd output
      pulse_reset();
      base = out_cnt;
      fd0  = fd_seen;
      fork
         begin
            for (int i = 0; i < 8; i++) send_rand();
            idle();
         end
         begin
            wait_outs(base + 2, "stall_wait");
            out_ready = 1'b0;
            @(negedge clk);
            held_a = fft_a;
            held_b = fft_b;
            check("stall_in_ready", 64'(in_ready), 64'(0));
            check("stall_out_valid", 64'(out_valid), 64'(1));
            repeat (3) begin
               @(negedge clk);
               check("stall_in_ready", 64'(in_ready), 64'(0));
               check("stall_hold_a", 64'(fft_a), 64'(held_a));
               check("stall_hold_b", 64'(fft_b), 64'(held_b));
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain("drain_stall");
      check("stall_frame_count", 64'(out_cnt - base), 64'(8));
      check("stall_frame_done_count", 64'(fd_seen - fd0), 64'(1));

      // Reset mid-frame after the 3rd output, then a clean frame
      pulse_reset();
      base = out_cnt;
      send_vec(tbl[2]);
      for (int i = 0; i < 4; i++) send_rand();
      idle();
      wait_outs(base + 3, "midframe_wait");
      rst = 1'b1;
      @(negedge clk);
      check("midrst_out_valid", 64'(out_valid), 64'(0));
      check("midrst_fft_a",     64'(fft_a),     64'(0));
      check("midrst_fft_b",     64'(fft_b),     64'(0));
      check("midrst_ovf",       64'(ovf),       64'(0));
      check("midrst_in_ready",  64'(in_ready),  64'(1));
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      check("postrst_out_valid", 64'(out_valid), 64'(0));
      @(posedge clk);
      #1;
      base = out_cnt;
      fd0  = fd_seen;
      for (int i = 0; i < 8; i++) send_rand();
      idle();
      drain("drain_postrst");
      check("postrst_frame_count", 64'(out_cnt - base), 64'(8));
      check("postrst_frame_done_count", 64'(fd_seen - fd0), 64'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
